// File: rtl/sseg_x4_decoder_if.sv
// Bus bundle between a multiplexed 4-digit 7-segment source and the decoder.
// The master drives the display pins and observes the decoded results; the
// slave is the decoder itself.
interface sseg_x4_decoder_if;
  logic [6:0] sseg_ca;      // {g,f,e,d,c,b,a}, active low
  logic [3:0] sseg_an;      // bit N selects digit N, active low
  logic [3:0] bcd0;
  logic [3:0] bcd1;
  logic [3:0] bcd2;
  logic [3:0] bcd3;
  logic       frame_valid;
  logic       an_err;
  logic       seg_err;
  logic [7:0] err_count;

  modport master (
    output sseg_ca,
    output sseg_an,
    input  bcd0,
    input  bcd1,
    input  bcd2,
    input  bcd3,
    input  frame_valid,
    input  an_err,
    input  seg_err,
    input  err_count
  );

  modport slave (
    input  sseg_ca,
    input  sseg_an,
    output bcd0,
    output bcd1,
    output bcd2,
    output bcd3,
    output frame_valid,
    output an_err,
    output seg_err,
    output err_count
  );
endinterface

// File: rtl/sseg_x4_decoder.sv
// Receive-side decoder for a 4-digit multiplexed common-anode 7-segment bus.
// Synchronizes the pins, waits for a stable pattern, classifies it and
// rebuilds the four BCD digits, pulsing frame_valid once all four are seen.
module sseg_x4_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic              clk,
  input logic              rst_n,
  sseg_x4_decoder_if.slave bus
);

  localparam logic [7:0] CntMax = 8'(STABLE_CYCLES - 1);

  logic [3:0] an_meta_q, an_sync_q, an_prev_q;
  logic [6:0] ca_meta_q, ca_sync_q, ca_prev_q;
  logic [7:0] cnt_q, cnt_d;
  logic       fired_q, fired_d;
  logic       capture;

  logic [3:0][3:0] bcd_q, bcd_d;
  logic [3:0]      seen_q, seen_d;
  logic            frame_valid_q, frame_valid_d;
  logic            an_err_q, an_err_d;
  logic            seg_err_q, seg_err_d;
  logic [7:0]      err_count_q, err_count_d;

  logic [3:0] an_sel;
  logic       an_idle, an_multi;
  logic [1:0] digit_idx;
  logic       seg_ok;
  logic [3:0] seg_val;

  // Two-flop synchronizers plus a one-cycle history for change detection.
  // Idle bus (all ones) is the reset value so nothing looks like a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_meta_q <= '1;
      an_sync_q <= '1;
      an_prev_q <= '1;
      ca_meta_q <= '1;
      ca_sync_q <= '1;
      ca_prev_q <= '1;
    end else begin
      an_meta_q <= bus.sseg_an;
      an_sync_q <= an_meta_q;
      an_prev_q <= an_sync_q;
      ca_meta_q <= bus.sseg_ca;
      ca_sync_q <= ca_meta_q;
      ca_prev_q <= ca_sync_q;
    end
  end

  // Stability filter: count unchanged cycles, fire a single capture per run.
  always_comb begin
    cnt_d   = cnt_q;
    fired_d = fired_q;
    capture = 1'b0;
    if ({an_sync_q, ca_sync_q} != {an_prev_q, ca_prev_q}) begin
      cnt_d   = '0;
      fired_d = 1'b0;
    end else if (cnt_q == CntMax) begin
      if (!fired_q) begin
        capture = 1'b1;
        fired_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Anode classification: idle, exactly one digit selected, or several.
  always_comb begin
    an_sel    = ~an_sync_q;
    an_idle   = (an_sel == 4'b0000);
    an_multi  = |(an_sel & (an_sel - 4'd1));
    digit_idx = 2'd0;
    unique case (an_sel)
      4'b0001: digit_idx = 2'd0;
      4'b0010: digit_idx = 2'd1;
      4'b0100: digit_idx = 2'd2;
      4'b1000: digit_idx = 2'd3;
      default: digit_idx = 2'd0;
    endcase
  end

  // Segment decode table; 7F is a blanked digit reported as F.
  always_comb begin
    seg_ok  = 1'b1;
    seg_val = 4'h0;
    case (ca_sync_q)
      7'h40:   seg_val = 4'h0;
      7'h79:   seg_val = 4'h1;
      7'h24:   seg_val = 4'h2;
      7'h30:   seg_val = 4'h3;
      7'h19:   seg_val = 4'h4;
      7'h12:   seg_val = 4'h5;
      7'h02:   seg_val = 4'h6;
      7'h78:   seg_val = 4'h7;
      7'h00:   seg_val = 4'h8;
      7'h10:   seg_val = 4'h9;
      7'h7F:   seg_val = 4'hF;
      default: seg_ok  = 1'b0;
    endcase
  end

  // Digit update, frame tracking and error accounting.
  always_comb begin
    bcd_d         = bcd_q;
    // A full frame clears progress, but a capture on the same edge survives.
    seen_d        = (seen_q == 4'b1111) ? 4'b0000 : seen_q;
    frame_valid_d = (seen_q == 4'b1111);
    an_err_d      = 1'b0;
    seg_err_d     = 1'b0;
    if (capture && !an_idle) begin
      if (an_multi) begin
        an_err_d = 1'b1;
      end else if (seg_ok) begin
        bcd_d[digit_idx]  = seg_val;
        seen_d[digit_idx] = 1'b1;
      end else begin
        seg_err_d = 1'b1;
      end
    end
    err_count_d = err_count_q;
    if ((an_err_d || seg_err_d) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      fired_q       <= 1'b0;
      bcd_q         <= '0;
      seen_q        <= '0;
      frame_valid_q <= 1'b0;
      an_err_q      <= 1'b0;
      seg_err_q     <= 1'b0;
      err_count_q   <= '0;
    end else begin
      cnt_q         <= cnt_d;
      fired_q       <= fired_d;
      bcd_q         <= bcd_d;
      seen_q        <= seen_d;
      frame_valid_q <= frame_valid_d;
      an_err_q      <= an_err_d;
      seg_err_q     <= seg_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign bus.bcd0        = bcd_q[0];
  assign bus.bcd1        = bcd_q[1];
  assign bus.bcd2        = bcd_q[2];
  assign bus.bcd3        = bcd_q[3];
  assign bus.frame_valid = frame_valid_q;
  assign bus.an_err      = an_err_q;
  assign bus.seg_err     = seg_err_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_sseg_x4_decoder.sv
// Bench for sseg_x4_decoder: table of display patterns with expected digits,
// pulse counts and error count, queued as stimulus is driven and checked
// once each hold window has elapsed, plus reset, glitch and saturation runs.
module tb_sseg_x4_decoder;

  localparam int unsigned Stable = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sseg_x4_decoder_if bus ();

  sseg_x4_decoder #(
    .STABLE_CYCLES(Stable)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  ca;
    int          hold;
    logic [15:0] bcd;   // {bcd3,bcd2,bcd1,bcd0}
    int          fv;
    int          ae;
    int          se;
    logic [7:0]  ec;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[15];

  int n_pass = 0;
  int n_total = 0;
  int fv_seen, ae_seen, se_seen;
  int coincide = 0;
  bit saw6 = 1'b0;

  function automatic vec_t mk(input logic [3:0] an, input logic [6:0] ca, input int hold,
                              input logic [15:0] bcd, input int fv, input int ae, input int se,
                              input logic [7:0] ec);
    vec_t v;
    v.an = an; v.ca = ca; v.hold = hold; v.bcd = bcd;
    v.fv = fv; v.ae = ae; v.se = se; v.ec = ec;
    return v;
  endfunction

  function automatic logic [15:0] bcd_all();
    return {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive a pattern and watch the outputs one tick after each rising edge.
  task automatic drive_hold(input logic [3:0] an, input logic [6:0] ca, input int hold);
    bus.sseg_an = an;
    bus.sseg_ca = ca;
    fv_seen = 0;
    ae_seen = 0;
    se_seen = 0;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (bus.frame_valid) fv_seen++;
      if (bus.an_err) ae_seen++;
      if (bus.seg_err) se_seen++;
      if (bus.an_err && bus.seg_err) coincide++;
      if (bus.bcd0 == 4'h6) saw6 = 1'b1;
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    vec_t e;
    exp_q.push_back(v);
    drive_hold(v.an, v.ca, v.hold);
    e = exp_q.pop_front();
    check({name, "/bcd"}, 32'(bcd_all()), 32'(e.bcd));
    check({name, "/frame_valid"}, 32'(fv_seen), 32'(e.fv));
    check({name, "/an_err"}, 32'(ae_seen), 32'(e.ae));
    check({name, "/seg_err"}, 32'(se_seen), 32'(e.se));
    check({name, "/err_count"}, 32'(bus.err_count), 32'(e.ec));
  endtask

  initial begin
    int total_ae;
    int total_se;
    int total_fv;

    // Rotation twice, then error and blank cases and a frame held open by a bad digit.
    tbl[0]  = mk(4'hE, 7'h79, 8, 16'h0001, 0, 0, 0, 8'd0);
    tbl[1]  = mk(4'hD, 7'h24, 8, 16'h0021, 0, 0, 0, 8'd0);
    tbl[2]  = mk(4'hB, 7'h30, 8, 16'h0321, 0, 0, 0, 8'd0);
    tbl[3]  = mk(4'h7, 7'h19, 8, 16'h4321, 1, 0, 0, 8'd0);
    tbl[4]  = mk(4'hE, 7'h79, 8, 16'h4321, 0, 0, 0, 8'd0);
    tbl[5]  = mk(4'hD, 7'h24, 8, 16'h4321, 0, 0, 0, 8'd0);
    tbl[6]  = mk(4'hB, 7'h30, 8, 16'h4321, 0, 0, 0, 8'd0);
    tbl[7]  = mk(4'h7, 7'h19, 8, 16'h4321, 1, 0, 0, 8'd0);
    tbl[8]  = mk(4'hC, 7'h40, 8, 16'h4321, 0, 1, 0, 8'd1);
    tbl[9]  = mk(4'hB, 7'h55, 8, 16'h4321, 0, 0, 1, 8'd2);
    tbl[10] = mk(4'hE, 7'h40, 8, 16'h4320, 0, 0, 0, 8'd2);
    tbl[11] = mk(4'hD, 7'h24, 8, 16'h4320, 0, 0, 0, 8'd2);
    tbl[12] = mk(4'h7, 7'h7F, 8, 16'hF320, 0, 0, 0, 8'd2);
    tbl[13] = mk(4'hF, 7'h7F, 8, 16'hF320, 0, 0, 0, 8'd2);
    tbl[14] = mk(4'hB, 7'h02, 8, 16'hF620, 1, 0, 0, 8'd2);

    bus.sseg_an = 4'hF;
    bus.sseg_ca = 7'h7F;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/bcd", 32'(bcd_all()), 32'h0);
    check("reset/frame_valid", 32'(bus.frame_valid), 32'h0);
    check("reset/an_err", 32'(bus.an_err), 32'h0);
    check("reset/seg_err", 32'(bus.seg_err), 32'h0);
    check("reset/err_count", 32'(bus.err_count), 32'h0);
    rst_n = 1'b1;
    drive_hold(4'hF, 7'h7F, 4);

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Short glitch on digit 0 must never be captured.
    apply(mk(4'hE, 7'h12, 8, 16'hF625, 0, 0, 0, 8'd2), "pre_glitch");
    saw6 = 1'b0;
    apply(mk(4'hE, 7'h02, 3, 16'hF625, 0, 0, 0, 8'd2), "glitch");
    apply(mk(4'hE, 7'h40, 8, 16'hF620, 0, 0, 0, 8'd2), "post_glitch");
    check("glitch_never_shown", 32'(saw6), 32'h0);

    // Reset in the middle of a frame drops partial progress.
    apply(mk(4'hE, 7'h79, 8, 16'hF621, 0, 0, 0, 8'd2), "mid_d0");
    apply(mk(4'hD, 7'h24, 8, 16'hF621, 0, 0, 0, 8'd2), "mid_d1");
    bus.sseg_an = 4'hF;
    bus.sseg_ca = 7'h7F;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst/bcd", 32'(bcd_all()), 32'h0);
    check("midrst/err_count", 32'(bus.err_count), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(mk(4'hF, 7'h7F, 4, 16'h0000, 0, 0, 0, 8'd0), "after_rst_idle");
    apply(mk(4'hB, 7'h30, 8, 16'h0300, 0, 0, 0, 8'd0), "after_rst_d2");
    apply(mk(4'h7, 7'h19, 8, 16'h4300, 0, 0, 0, 8'd0), "after_rst_d3");
    apply(mk(4'hE, 7'h79, 8, 16'h4301, 0, 0, 0, 8'd0), "after_rst_d0");
    apply(mk(4'hD, 7'h24, 8, 16'h4321, 1, 0, 0, 8'd0), "after_rst_d1");

    // 300 anode errors: the counter must stop at 255.
    total_ae = 0;
    total_se = 0;
    total_fv = 0;
    for (int i = 0; i < 300; i++) begin
      drive_hold((i % 2 == 0) ? 4'hC : 4'h3, 7'h40, 8);
      total_ae += ae_seen;
      total_se += se_seen;
      total_fv += fv_seen;
    end
    check("sat/an_err_pulses", 32'(total_ae), 32'd300);
    check("sat/seg_err_pulses", 32'(total_se), 32'd0);
    check("sat/frame_valid", 32'(total_fv), 32'd0);
    check("sat/err_count", 32'(bus.err_count), 32'hFF);
    check("sat/bcd", 32'(bcd_all()), 32'h4321);
    check("err_exclusive", 32'(coincide), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sseg_x4_decoder.md
Name: sseg_x4_decoder

Overview:
- Receive-side counterpart of the 4-digit multiplexed 7-segment driver.
- Samples a time-multiplexed common-anode bus (active-LOW cathodes and anodes) and reconstructs the four displayed BCD digits.
- Signals each complete refresh frame and flags malformed anode or segment patterns.
- Used as a loopback checker for the stopwatch display path and as a front end for reading an external display.

Parameters:
- STABLE_CYCLES, 4, consecutive clocks a synchronized {an,ca} pattern must stay unchanged before it is sampled. Legal range is 1..255.

Ports:
- clk  input  1  posedge active clock, 100 MHz
- rst_n  input  1  async reset, active LOW
- sseg_ca  input  7  segment cathodes {g,f,e,d,c,b,a}, active LOW
- sseg_an  input  4  anodes, active LOW; bit N selects digit N
- bcd0  output  4  reconstructed digit 0
- bcd1  output  4  reconstructed digit 1
- bcd2  output  4  reconstructed digit 2
- bcd3  output  4  reconstructed digit 3
- frame_valid  output  1  1-cycle pulse: all four digits captured since the previous pulse
- an_err  output  1  1-cycle pulse: sampled anode pattern had two or more zeros
- seg_err  output  1  1-cycle pulse: sampled segment pattern not in the decode table
- err_count  output  8  saturating count of an_err plus seg_err events

Behaviour:
- Reset (async, rst_n=0) clears all of the following: bcd0..3=4'h0, frame_valid=0, an_err=0, seg_err=0, err_count=0, synchronizer flops=all ones, stability counter=0, digit_seen=4'b0000.
- Input stage: sseg_an and sseg_ca each pass through a 2-FF synchronizer.
- Stability filter:
  - A counter compares the synchronized {an,ca} with its value on the previous cycle.
  - Any difference resets the counter to 0.
  - When the counter reaches STABLE_CYCLES-1, one capture event fires and the counter holds. At most one capture fires per stable run.
- Capture classification (an = synchronized anodes):
  - an = 4'b1111: idle or blanking interval. No update, no error.
  - Exactly one zero at bit N: decode the cathodes.
  - Two or more zeros: an_err pulse, err_count+1. No digit updated.
- Decode table (ca hex → bcd): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 7F→F (blank).
  - Any other ca pattern: seg_err pulse, err_count+1, bcdN unchanged, digit_seen[N] unchanged.
- Valid capture on digit N: bcdN is updated on the next clock edge and digit_seen[N] is set.
- Latency: a pattern applied before edge k and held makes bcdN valid after edge k+2+STABLE_CYCLES.
- Frame completion:
  - When digit_seen==4'b1111, frame_valid pulses for one cycle and digit_seen is cleared on the same edge.
  - If a valid capture happens on that same edge, its bit survives the clear.
- Repeated captures of the same digit within a frame overwrite bcdN; this does not produce an extra frame_valid.
- err_count saturates at 8'hFF.
  - an_err and seg_err cannot coincide, because an_err captures skip decoding.
- Reset asserted mid-frame discards partial progress. After release, four fresh digit captures are required before the next frame_valid.

Test Plan:
- Rotate an 1110→1101→1011→0111 with ca 79,24,30,19, each held 8 clk, STABLE_CYCLES=4 → bcd0..3=1,2,3,4; frame_valid pulses once per rotation, 1 clk after bcd3 updates; no errors.
- Digit 0 held 3 clk with ca=02, then normal 8-clk hold with ca=40 → bcd0=0; the value 6 never appears; no error.
- an=1100 held 8 clk → an_err single pulse, err_count=1, bcd0..3 unchanged, digit_seen unchanged.
- an=1011 with ca=7'h55 → seg_err pulse, err_count increments, bcd2 keeps its previous value; with no valid digit-2 capture, the frame does not complete.
- ca=7F on digit 3 → bcd3=4'hF, no error, counts toward frame.
- Capture digits 0 and 1, pulse rst_n low for 1 clk, then capture digits 2 and 3 only → all outputs zero after reset, no frame_valid. Complete the remaining digits → frame_valid.
- 300 consecutive an_err events → err_count stops at 255.
